lsu_pipe: RTL

- Parametrised load/store unit replacing the single-cycle combinational memory stage.
- Sits between EX and WB. Drives a req/gnt/rvalid data-memory bus with byte strobes, so stores need no read-modify-write.
- Stalls the pipeline while a memory access is in flight and registers results to WB.
- Detects misaligned accesses; an optional bus timeout is available.

---
 rtl/lsu_pipe.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lsu_pipe.sv
// lsu_pipe: load/store unit driving a req/gnt/rvalid data bus with byte strobes and registered WB outputs.
// Optional bus timeout enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu_pipe #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              is_mem_i,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic              reg_we_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic [XLEN-1:0]   reg_wdata_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              wb_valid_o,
    output logic              reg_we_o,
    output logic [4:0]        reg_waddr_o,
    output logic [XLEN-1:0]   reg_wdata_o,
    output logic              exc_o,
    output logic [ADDR_W-1:0] exc_addr_o
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t state, state_n;

    logic [OW-1:0]     off, off_q;
    logic              misal, accept, done, to, tout;
    logic [NB-1:0]     strb;
    logic [XLEN-1:0]   wdata, sh, fmt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q, st_q;
    logic [4:0]        waddr_q;

    assign off    = addr_i[OW-1:0];
    // Doubleword is illegal outright on a 32-bit datapath
    assign misal  = size_i == 2'd1 ? addr_i[0] :
                    size_i == 2'd2 ? |addr_i[1:0] :
                    size_i == 2'd3 ? (XLEN == 32 || |addr_i[2:0]) : 1'b0;
    assign accept = state == S_IDLE && valid_i && is_mem_i && !misal;
    assign strb   = (size_i == 2'd0 ? NB'(1) : size_i == 2'd1 ? NB'(3) :
                     size_i == 2'd2 ? NB'(15) : {NB{1'b1}}) << off;
    assign wdata  = store_data_i << {off, 3'b000};
    assign sh     = mem_rdata_i >> {off_q, 3'b000};
    assign fmt    = size_q == 2'd0 ? (uns_q ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]))) :
                    size_q == 2'd1 ? (uns_q ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
                    size_q == 2'd2 ? (uns_q ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
    assign done   = (state == S_REQ && mem_gnt_i && mem_rvalid_i) || (state == S_WAIT && mem_rvalid_i);
    assign tout   = to && !done;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    assign to = state != S_IDLE && cnt == CW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (state_n != state || state == S_IDLE) ? '0 : cnt + 1'b1;
`else
    assign to = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_n;

    always_comb
        state_n = state == S_IDLE ? (accept ? S_REQ : S_IDLE) :
                  (done || tout) ? S_IDLE :
                  (state == S_REQ && mem_gnt_i) ? S_WAIT : state;

    always_comb begin
        stall_o   = accept || (state != S_IDLE && !done && !tout);
        mem_req_o = state == S_REQ;
        mem_we_o  = state == S_REQ && st_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_o  <= '0;
            mem_wstrb_o <= '0;
            mem_wdata_o <= '0;
            wb_valid_o  <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            exc_o       <= 1'b0;
            exc_addr_o  <= '0;
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            st_q        <= 1'b0;
            waddr_q     <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            reg_we_o   <= 1'b0;
            exc_o      <= 1'b0;
            if (state == S_IDLE && valid_i) begin
                if (!is_mem_i) begin
                    wb_valid_o  <= 1'b1;
                    reg_we_o    <= reg_we_i && |reg_waddr_i;
                    reg_waddr_o <= reg_waddr_i;
                    reg_wdata_o <= reg_wdata_i;
                end else if (misal) begin
                    wb_valid_o <= 1'b1;
                    exc_o      <= 1'b1;
                    exc_addr_o <= addr_i;
                end else begin
                    mem_addr_o  <= {addr_i[ADDR_W-1:OW], {OW{1'b0}}};
                    mem_wstrb_o <= strb;
                    mem_wdata_o <= wdata;
                    addr_q      <= addr_i;
                    off_q       <= off;
                    size_q      <= size_i;
                    uns_q       <= unsigned_i;
                    st_q        <= is_store_i;
                    waddr_q     <= reg_waddr_i;
                end
            end
            if (done) begin
                wb_valid_o  <= 1'b1;
                reg_we_o    <= !st_q && |waddr_q;
                reg_waddr_o <= waddr_q;
                reg_wdata_o <= fmt;
            end
            if (tout) begin
                wb_valid_o <= 1'b1;
                exc_o      <= 1'b1;
                exc_addr_o <= addr_q;
            end
        end
    end
endmodule
